// File: rtl/dds_phase_generator.sv
// DDS phase accumulator with AXI-Stream style phase output, shadowed pinc/poff
// config, sync clear and overflow counting. DDS_PHASE_DITHER_EN adds LFSR dither.
module dds_phase_generator #(
  parameter int unsigned PHASE_WIDTH    = 48,
  parameter int unsigned WRAP_CNT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [PHASE_WIDTH-1:0]    cfg_pinc,
  input  logic [PHASE_WIDTH-1:0]    cfg_poff,
  input  logic                      cfg_update,
  input  logic                      sync,
  output logic [PHASE_WIDTH-1:0]    m_axis_tdata_phase,
  output logic                      m_axis_tvalid_phase,
  input  logic                      m_axis_tready_phase,
  output logic                      wrap,
  output logic [WRAP_CNT_WIDTH-1:0] wrap_count
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state_q, state_d;
  logic [PHASE_WIDTH-1:0]    acc_q, acc_d;
  logic [PHASE_WIDTH-1:0]    pinc_q, pinc_d, poff_q, poff_d;
  logic [PHASE_WIDTH-1:0]    pend_pinc_q, pend_pinc_d, pend_poff_q, pend_poff_d;
  logic                      pend_q, pend_d;
  logic                      sync_pend_q, sync_pend_d;
  logic [PHASE_WIDTH-1:0]    tdata_q, tdata_d;
  logic                      tvalid_q, tvalid_d;
  logic                      wrap_q, wrap_d;
  logic [WRAP_CNT_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [PHASE_WIDTH:0]      sum_c;
  logic [PHASE_WIDTH-1:0]    dith_c;
  logic                      hs_c;

  assign hs_c  = tvalid_q & m_axis_tready_phase;
  assign sum_c = {1'b0, acc_q} + {1'b0, pinc_q};

`ifdef DDS_PHASE_DITHER_EN
  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, stepped once per handshake
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (hs_c) lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    dith_c = PHASE_WIDTH'(lfsr_d);
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end
`else
  assign dith_c = '0;
`endif

  // Next-state: a new word is formed from the post-edge acc/poff values
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    pinc_d      = pinc_q;
    poff_d      = poff_q;
    pend_pinc_d = pend_pinc_q;
    pend_poff_d = pend_poff_q;
    pend_d      = pend_q;
    sync_pend_d = sync_pend_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    wrap_d      = 1'b0;
    wcnt_d      = wcnt_q;

    case (state_q)
      IDLE: begin
        pend_d      = 1'b0;
        sync_pend_d = 1'b0;
        if (cfg_update) begin
          pinc_d = cfg_pinc;
          poff_d = cfg_poff;
        end
        if (sync) acc_d = '0;
        if (enable) begin
          state_d  = RUN;
          tvalid_d = 1'b1;
          tdata_d  = acc_d + poff_d + dith_c;
        end
      end
      RUN: begin
        if (cfg_update) begin
          pend_pinc_d = cfg_pinc;
          pend_poff_d = cfg_poff;
          pend_d      = 1'b1;
        end
        // Clear acc now; remember so the next handshake skips its increment
        if (sync) begin
          acc_d       = '0;
          sync_pend_d = 1'b1;
        end
        if (hs_c) begin
          if (sync || sync_pend_q) begin
            acc_d = '0;
          end else begin
            acc_d  = sum_c[PHASE_WIDTH-1:0];
            wrap_d = sum_c[PHASE_WIDTH];
            wcnt_d = wcnt_q + WRAP_CNT_WIDTH'(sum_c[PHASE_WIDTH]);
          end
          if (pend_d) begin
            pinc_d = pend_pinc_d;
            poff_d = pend_poff_d;
          end
          pend_d      = 1'b0;
          sync_pend_d = 1'b0;
          tdata_d     = acc_d + poff_d + dith_c;
          if (!enable) begin
            state_d  = IDLE;
            tvalid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      pinc_q      <= '0;
      poff_q      <= '0;
      pend_pinc_q <= '0;
      pend_poff_q <= '0;
      pend_q      <= 1'b0;
      sync_pend_q <= 1'b0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      wrap_q      <= 1'b0;
      wcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      pinc_q      <= pinc_d;
      poff_q      <= poff_d;
      pend_pinc_q <= pend_pinc_d;
      pend_poff_q <= pend_poff_d;
      pend_q      <= pend_d;
      sync_pend_q <= sync_pend_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      wrap_q      <= wrap_d;
      wcnt_q      <= wcnt_d;
    end
  end

  assign m_axis_tdata_phase  = tdata_q;
  assign m_axis_tvalid_phase = tvalid_q;
  assign wrap                = wrap_q;
  assign wrap_count          = wcnt_q;

endmodule

// File: tb/tb_dds_phase_generator.sv
// Directed bench for dds_phase_generator: per-cycle vector table plus wrap,
// stall and (when DDS_PHASE_DITHER_EN is defined) dither sequences.
module tb_dds_phase_generator;

  localparam int unsigned PW = 48;
  localparam int unsigned WW = 32;

  logic          clk;
  logic          reset, enable, cfg_update, sync, tready;
  logic [PW-1:0] cfg_pinc, cfg_poff;
  logic [PW-1:0] tdata;
  logic          tvalid, wrap;
  logic [WW-1:0] wrap_count;

  int nvec;
  int nerr;

  dds_phase_generator #(.PHASE_WIDTH(PW), .WRAP_CNT_WIDTH(WW)) dut (
    .clk                 (clk),
    .reset               (reset),
    .enable              (enable),
    .cfg_pinc            (cfg_pinc),
    .cfg_poff            (cfg_poff),
    .cfg_update          (cfg_update),
    .sync                (sync),
    .m_axis_tdata_phase  (tdata),
    .m_axis_tvalid_phase (tvalid),
    .m_axis_tready_phase (tready),
    .wrap                (wrap),
    .wrap_count          (wrap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst, en, rdy, upd, syn;
    logic [PW-1:0] pinc, poff;
    logic          vld;
    logic          chk_data;
    logic [PW-1:0] data;
    logic          wrp;
    logic [WW-1:0] wcnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic en, logic rdy, logic upd, logic syn,
                              logic [PW-1:0] pinc, logic [PW-1:0] poff,
                              logic vld, logic chk_data, logic [PW-1:0] data,
                              logic wrp, logic [WW-1:0] wcnt);
    vec_t v;
    v.rst = rst; v.en = en; v.rdy = rdy; v.upd = upd; v.syn = syn;
    v.pinc = pinc; v.poff = poff; v.vld = vld; v.chk_data = chk_data;
    v.data = data; v.wrp = wrp; v.wcnt = wcnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic en, input logic rdy, input logic upd,
                       input logic syn, input logic [PW-1:0] pinc, input logic [PW-1:0] poff);
    reset = rst; enable = en; tready = rdy; cfg_update = upd; sync = syn;
    cfg_pinc = pinc; cfg_poff = poff;
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  initial begin
    logic [PW-1:0] p;
    logic [PW-1:0] exp_d;
    logic [15:0]   l;
    nvec = 0;
    nerr = 0;
    drive(1, 0, 0, 0, 0, '0, '0);

`ifndef DDS_PHASE_DITHER_EN
    //          rst en rdy upd syn pinc   poff    vld cd data    wrp wcnt
    tbl.push_back(mk(1, 0, 0, 0, 0, 48'd0, 48'h0,   0, 1, 48'h0,   0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 48'd5, 48'h100, 0, 1, 48'h0,   0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 48'd0, 48'h0,   1, 1, 48'h100, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 48'd0, 48'h0,   1, 1, 48'h100, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 48'd0, 48'h0,   1, 1, 48'h105, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 48'd0, 48'h0,   1, 1, 48'h10A, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 48'd0, 48'h0,   1, 1, 48'h10A, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 48'd1, 48'h10,  1, 1, 48'h10A, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 48'd0, 48'h0,   1, 1, 48'h1F,  0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 48'd0, 48'h0,   1, 1, 48'h20,  0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 48'd0, 48'h0,   1, 1, 48'h20,  0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 48'd0, 48'h0,   1, 1, 48'h10,  0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 48'd0, 48'h0,   1, 1, 48'h11,  0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 48'd0, 48'h0,   1, 1, 48'h10,  0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 48'd0, 48'h0,   0, 0, 48'h0,   0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 48'd0, 48'h0,   0, 0, 48'h0,   0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 48'd2, 48'h40,  1, 1, 48'h40,  0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 48'd0, 48'h0,   1, 1, 48'h42,  0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 48'd3, 48'h80,  1, 1, 48'h80,  0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 48'd0, 48'h0,   1, 1, 48'h83,  0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 48'd7, 48'h0,   1, 1, 48'h83,  0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 48'd9, 48'h200, 1, 1, 48'h83,  0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 48'd0, 48'h0,   1, 1, 48'h206, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 48'd0, 48'h0,   1, 1, 48'h20F, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 48'd0, 48'h0,   0, 1, 48'h0,   0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 48'd0, 48'h0,   1, 1, 48'h0,   0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 48'd0, 48'h0,   1, 1, 48'h0,   0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 48'd0, 48'h0,   0, 0, 48'h0,   0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].rdy, tbl[i].upd, tbl[i].syn, tbl[i].pinc, tbl[i].poff);
      tick();
      chk($sformatf("vec%0d.tvalid", i), 64'(tvalid), 64'(tbl[i].vld));
      if (tbl[i].chk_data) chk($sformatf("vec%0d.tdata", i), 64'(tdata), 64'(tbl[i].data));
      chk($sformatf("vec%0d.wrap", i), 64'(wrap), 64'(tbl[i].wrp));
      chk($sformatf("vec%0d.wrap_count", i), 64'(wrap_count), 64'(tbl[i].wcnt));
    end

    // Full-cycle sweep: 16 increments of 2^44 overflow exactly once
    p = 48'h1000_0000_0000;
    drive(1, 0, 0, 0, 0, '0, '0);
    tick();
    drive(0, 0, 0, 1, 0, p, '0);
    tick();
    drive(0, 1, 1, 0, 0, '0, '0);
    tick();
    chk("wrap_first.tdata", 64'(tdata), 64'h0);
    chk("wrap_first.tvalid", 64'(tvalid), 64'h1);
    for (int k = 1; k <= 17; k++) begin
      tick();
      exp_d = p * PW'(k);
      chk($sformatf("sweep%0d.tdata", k), 64'(tdata), 64'(exp_d));
      chk($sformatf("sweep%0d.wrap", k), 64'(wrap), (k == 16) ? 64'h1 : 64'h0);
      chk($sformatf("sweep%0d.wrap_count", k), 64'(wrap_count), (k >= 16) ? 64'h1 : 64'h0);
    end

    // Five-cycle stall holds word and count
    tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("stall%0d.tdata", k), 64'(tdata), 64'(p));
      chk($sformatf("stall%0d.tvalid", k), 64'(tvalid), 64'h1);
    end
    tready = 1'b1;
    tick();
    chk("resume.tdata", 64'(tdata), 64'(p * 48'd2));
    chk("resume.wrap_count", 64'(wrap_count), 64'h1);

    // Reset during a stall discards the word and clears the count
    tready = 1'b0;
    reset  = 1'b1;
    tick();
    chk("rst_stall.tvalid", 64'(tvalid), 64'h0);
    chk("rst_stall.wrap_count", 64'(wrap_count), 64'h0);
    reset = 1'b0;
    tready = 1'b1;
    tick();
    chk("rst_stall.acc0", 64'(tdata), 64'h0);
`else
    drive(1, 0, 0, 0, 0, '0, '0);
    tick();
    drive(0, 0, 0, 1, 0, '0, '0);
    tick();
    drive(0, 1, 1, 0, 0, '0, '0);
    tick();
    l = 16'hACE1;
    chk("dither0.tdata", 64'(tdata), 64'hACE1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      l = lfsr_step(l);
      chk($sformatf("dither%0d.tdata", k), 64'(tdata), 64'(l));
      chk($sformatf("dither%0d.wrap", k), 64'(wrap), 64'h0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
